// File: rtl/fip_div_scheduler_if.sv
// Requester, divider and response signal bundle for fip_div_scheduler.
// The scheduler uses the slave view; its environment uses the master view.
interface fip_div_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_x;
  logic [32*N_REQ-1:0] req_y;
  logic [N_REQ-1:0]    req_ready;
  logic                hold;
  logic                div_en;
  logic [31:0]         div_x;
  logic [31:0]         div_y;
  logic [31:0]         div_z;
  logic                div_valid;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_z;
  logic                rsp_dz;
  logic                busy;
  logic                err;

  modport slave (
    input  req_valid, req_x, req_y, hold,
    input  div_z, div_valid,
    output req_ready, div_en, div_x, div_y,
    output rsp_valid, rsp_z, rsp_dz, busy, err
  );

  modport master (
    output req_valid, req_x, req_y, hold,
    output div_z, div_valid,
    input  req_ready, div_en, div_x, div_y,
    input  rsp_valid, rsp_z, rsp_dz, busy, err
  );
endinterface

// File: rtl/fip_div_scheduler.sv
// Round-robin sharing of one pipelined Q16.16 divider among N_REQ requesters,
// with a tag pipeline that steers each quotient back to its owner.
module fip_div_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DIV_LAT = 50,
  parameter bit SAT     = 1'b1
) (
  input logic                i_clk,
  input logic                i_rstn,
  fip_div_scheduler_if.slave sif
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
    logic          dz;
    logic          xsign;
  } tag_t;

  logic [IW-1:0]    ptr;
  logic             gnt_any;
  logic [IW-1:0]    gnt_id;
  logic [N_REQ-1:0] grant;
  logic [31:0]      sel_x;
  logic [31:0]      sel_y;
  tag_t             tag_in;
  tag_t             tag_out;
  tag_t             tag_q [DIV_LAT+1];

  logic             div_en_q;
  logic [31:0]      div_x_q;
  logic [31:0]      div_y_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [31:0]      rsp_z_q;
  logic [31:0]      rsp_z_d;
  logic             rsp_dz_q;
  logic             err_q;
  logic             busy_d;

  // Rotating priority: search starts just after the last winner.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_w;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = IW'(idx);
      if (!gnt_any && sif.req_valid[idx_w]) begin
        gnt_any = 1'b1;
        gnt_id  = idx_w;
      end
    end
    if (!i_rstn || sif.hold) gnt_any = 1'b0;
  end

  always_comb begin
    grant = '0;
    sel_x = '0;
    sel_y = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_id == IW'(k)) begin
        sel_x = sif.req_x[32*k +: 32];
        sel_y = sif.req_y[32*k +: 32];
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  always_comb begin
    tag_in = '0;
    if (gnt_any) begin
      tag_in.valid = 1'b1;
      tag_in.id    = gnt_id;
      tag_in.dz    = (sel_y == 32'd0);
      tag_in.xsign = sel_x[31];
    end
  end

  assign tag_out = tag_q[DIV_LAT];

  always_comb begin
    rsp_z_d = sif.div_z;
    if (SAT && tag_out.dz) begin
      rsp_z_d = tag_out.xsign ? 32'h8000_0000 : 32'h7fff_ffff;
    end
  end

  always_comb begin
    busy_d = div_en_q;
    for (int s = 0; s <= DIV_LAT; s++) begin
      busy_d = busy_d | tag_q[s].valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ptr         <= IW'(N_REQ - 1);
      div_en_q    <= 1'b0;
      div_x_q     <= '0;
      div_y_q     <= '0;
      rsp_valid_q <= '0;
      rsp_z_q     <= '0;
      rsp_dz_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int s = 0; s <= DIV_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      div_en_q <= gnt_any;
      if (gnt_any) begin
        ptr     <= gnt_id;
        div_x_q <= sel_x;
        div_y_q <= sel_y;
      end
      tag_q[0] <= tag_in;
      for (int s = 1; s <= DIV_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      rsp_valid_q <= '0;
      if (tag_out.valid) begin
        rsp_valid_q[tag_out.id] <= 1'b1;
        rsp_z_q                 <= rsp_z_d;
        rsp_dz_q                <= tag_out.dz;
      end
      // A result with no owner, or an owner with no result, is never cleared.
      if (tag_out.valid != sif.div_valid) err_q <= 1'b1;
    end
  end

  assign sif.req_ready = grant;
  assign sif.div_en    = div_en_q;
  assign sif.div_x     = div_x_q;
  assign sif.div_y     = div_y_q;
  assign sif.rsp_valid = rsp_valid_q;
  assign sif.rsp_z     = rsp_z_q;
  assign sif.rsp_dz    = rsp_dz_q;
  assign sif.busy      = busy_d;
  assign sif.err       = err_q;
endmodule

// File: tb/tb_fip_div_scheduler.sv
// Bench for fip_div_scheduler: pipelined divider model, scoreboard,
// directed scenarios and randomized traffic.
module tb_fip_div_scheduler;
  localparam int N   = 4;
  localparam int LAT = 50;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic spur = 1'b0;

  always #5 clk = ~clk;

  fip_div_scheduler_if #(.N_REQ(N)) bus ();

  fip_div_scheduler #(
    .N_REQ  (N),
    .DIV_LAT(LAT),
    .SAT    (1'b1)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .sif   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Divider environment: fixed latency, reset together with the block.
  logic        pv [LAT];
  logic [31:0] pz [LAT];

  function automatic logic [31:0] qdiv(input logic [31:0] x,
                                       input logic [31:0] y);
    logic signed [63:0] n;
    logic signed [63:0] d;
    logic signed [63:0] r;
    if (y == 32'd0) return 32'hdead_beef;
    n = {{32{x[31]}}, x} <<< 16;
    d = {{32{y[31]}}, y};
    r = n / d;
    return r[31:0];
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= bus.div_en;
      pz[0] <= qdiv(bus.div_x, bus.div_y);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pz[i] <= pz[i-1];
      end
    end
  end

  assign bus.div_valid = pv[LAT-1] | spur;
  assign bus.div_z     = pz[LAT-1];

  // Reference model: Q16.16 quotient or saturation on a zero divisor.
  function automatic logic [31:0] ref_z(input logic [31:0] x,
                                        input logic [31:0] y);
    longint     xn;
    longint     yn;
    logic [63:0] r;
    if (y == 32'd0) return x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    xn = longint'($signed(x));
    yn = longint'($signed(y));
    r  = 64'((xn * 65536) / yn);
    return r[31:0];
  endfunction

  typedef struct {
    int          id;
    logic [31:0] z;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        q [$];
  int          grant_log [$];
  int          rsp_ids [$];
  logic [31:0] rsp_zs [$];
  logic        rsp_dzs [$];
  int          rsp_cycs [$];

  int          cyc       = 0;
  int          mptr      = N - 1;
  logic        err_exp   = 1'b0;
  logic        en_exp    = 1'b0;
  logic [31:0] x_exp     = '0;
  logic [31:0] y_exp     = '0;
  int          last_acc  = 0;
  int          busy_fall = 0;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] rv;
    exp_t         e;
    int           g;
    int           k;
    int           id;
    cyc++;
    rv = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      rv[e.id] = 1'b1;
      chk("rsp_z", bus.rsp_z, e.z);
      chk("rsp_dz", bus.rsp_dz, e.dz);
    end
    chk("rsp_valid", bus.rsp_valid, rv);
    chk("busy", bus.busy, q.size() != 0);
    chk("err", bus.err, err_exp);
    chk("div_en", bus.div_en, en_exp);
    if (en_exp) begin
      chk("div_x", bus.div_x, x_exp);
      chk("div_y", bus.div_y, y_exp);
    end
    if (bus.rsp_valid != '0) begin
      id = 0;
      for (int j = 0; j < N; j++) if (bus.rsp_valid[j]) id = j;
      rsp_ids.push_back(id);
      rsp_zs.push_back(bus.rsp_z);
      rsp_dzs.push_back(bus.rsp_dz);
      rsp_cycs.push_back(cyc);
    end
    if (busy_prev && !bus.busy) busy_fall = cyc;
    busy_prev = bus.busy;
    g = -1;
    if (rstn && !bus.hold) begin
      for (int i = 1; i <= N; i++) begin
        k = (mptr + i) % N;
        if (g < 0 && bus.req_valid[k]) g = k;
      end
    end
    chk("ready", bus.req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
    en_exp = 1'b0;
    if (!rstn) begin
      q.delete();
      mptr    = N - 1;
      err_exp = 1'b0;
    end else begin
      if (spur) err_exp = 1'b1;
      if (g >= 0) begin
        mptr   = g;
        en_exp = 1'b1;
        x_exp  = bus.req_x[32*g +: 32];
        y_exp  = bus.req_y[32*g +: 32];
        e.id   = g;
        e.z    = ref_z(x_exp, y_exp);
        e.dz   = (y_exp == 32'd0);
        e.due  = cyc + LAT + 2;
        q.push_back(e);
        grant_log.push_back(g);
        last_acc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_ids.delete();
    rsp_zs.delete();
    rsp_dzs.delete();
    rsp_cycs.delete();
  endtask

  task automatic set_req(input int k, input logic [31:0] x,
                         input logic [31:0] y);
    bus.req_x[32*k +: 32] = x;
    bus.req_y[32*k +: 32] = y;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.hold      = 1'b0;

    // Reset with every requester asserting valid.
    for (int k = 0; k < N; k++) set_req(k, (k + 1) << 16, 32'h0001_0000);
    bus.req_valid = '1;
    rstn = 1'b0;
    tick(3);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_div_en", bus.div_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_err", bus.err, 0);
    clear_logs();

    // Full load round robin straight out of reset.
    rstn = 1'b1;
    tick(8);
    bus.req_valid = '0;
    tick(LAT + 10);
    chk("rr_grants", grant_log.size(), 8);
    chk("rr_rsps", rsp_ids.size(), 8);
    for (int i = 0; i < 8 && i < rsp_ids.size() && i < grant_log.size(); i++) begin
      chk("rr_grant_id", grant_log[i], i % N);
      chk("rr_rsp_id", rsp_ids[i], i % N);
      chk("rr_rsp_z", rsp_zs[i], ((i % N) + 1) << 16);
      chk("rr_rsp_gap", rsp_cycs[i] - rsp_cycs[0], i);
    end

    // Single requester, 3.0 / 2.0.
    clear_logs();
    set_req(1, 32'h0003_0000, 32'h0002_0000);
    bus.req_valid = 4'b0010;
    tick(1);
    bus.req_valid = '0;
    tick(LAT + 10);
    chk("one_rsps", rsp_ids.size(), 1);
    if (rsp_ids.size() > 0) begin
      chk("one_id", rsp_ids[0], 1);
      chk("one_lat", rsp_cycs[0] - last_acc, LAT + 2);
      chk("one_z", rsp_zs[0], 32'h0001_8000);
      chk("one_dz", rsp_dzs[0], 0);
    end

    // Divide by zero, both signs.
    clear_logs();
    set_req(2, 32'hffff_0000, 32'h0);
    bus.req_valid = 4'b0100;
    tick(1);
    set_req(2, 32'h0001_0000, 32'h0);
    tick(1);
    bus.req_valid = '0;
    tick(LAT + 10);
    chk("dz_rsps", rsp_ids.size(), 2);
    if (rsp_ids.size() > 1) begin
      chk("dz_neg_z", rsp_zs[0], 32'h8000_0000);
      chk("dz_neg_dz", rsp_dzs[0], 1);
      chk("dz_pos_z", rsp_zs[1], 32'h7fff_ffff);
      chk("dz_pos_dz", rsp_dzs[1], 1);
    end

    // Hold with requests still pending, then drain.
    clear_logs();
    bus.req_valid = '1;
    tick(3);
    bus.hold = 1'b1;
    tick(LAT + 20);
    chk("hold_grants", grant_log.size(), 3);
    chk("hold_rsps", rsp_ids.size(), 3);
    chk("hold_busy_fall", busy_fall - (last_acc + 1), LAT + 1);
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    tick(2);

    // Spurious divider result sets a sticky error.
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(3);
    chk("err_set", bus.err, 1);
    tick(20);
    chk("err_sticky", bus.err, 1);
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(2);
    chk("err_cleared", bus.err, 0);

    // Reset with ten operations in flight.
    clear_logs();
    bus.req_valid = '1;
    tick(10);
    bus.req_valid = '0;
    tick(5);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(LAT + 20);
    chk("mid_rst_rsps", rsp_ids.size(), 0);
    chk("mid_rst_err", bus.err, 0);

    // Randomized traffic with occasional zero divisors and holds.
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid = N'($urandom);
      for (int k = 0; k < N; k++) begin
        set_req(k, $urandom,
                ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
      end
      bus.hold = ($urandom_range(0, 9) == 0);
      tick(1);
    end
    bus.req_valid = '0;
    bus.hold      = 1'b0;
    tick(LAT + 10);
    chk("sb_empty", q.size(), 0);
    chk("final_err", bus.err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
